// File: rtl/prbs31_chk32b_pkg.sv
// Shared PRBS31 definitions: word width, checker state encoding and the
// 32-bit parallel next-word function used by generator and checker alike.
package prbs31_pkg;

  localparam int PRBS_W = 32;

  typedef logic [0:0] state_t;
  localparam state_t SEARCH = 1'b0;
  localparam state_t LOCKED = 1'b1;

  // Advances x^31+x^28+1 by 32 bit-times; low nibble folds back the new MSBs.
  function automatic logic [PRBS_W-1:0] prbs31_nxt32(input logic [PRBS_W-1:0] p);
    logic [PRBS_W-1:0] n;
    n[31:4] = p[30:3] ^ p[27:0];
    n[3:0]  = {p[2:0], n[31]} ^ n[31:28];
    return n;
  endfunction

endpackage

// File: rtl/prbs31_chk32b_popcnt32.sv
// Combinational population count of a 32-bit vector (0..32).
module popcnt32 (
  input  logic [31:0] d,
  output logic [5:0]  cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + {5'b0, d[i]};
    end
  end

endmodule

// File: rtl/prbs31_chk32b.sv
// PRBS31 32-bit receive checker: self-syncs, free-runs a local generator and
// counts errors while locked. Define PRBS31_CHK_ERRMASK_EN to add err_mask.
//
// state  | meaning
// SEARCH | predicting from the previous received word, counting clean words
// LOCKED | comparing against the free-running local generator
module prbs31_chk32b
  import prbs31_pkg::*;
#(
  parameter int LOCK_CNT    = 16,
  parameter int UNLOCK_CNT  = 4,
  parameter int UNLOCK_BITS = 8,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_valid,
  input  logic [31:0]      din,
  input  logic             clr,
  output logic             locked,
  output logic             err_flag,
  output logic [5:0]       err_bits,
  output logic [CNT_W-1:0] err_bit_cnt,
  output logic [CNT_W-1:0] err_word_cnt,
  output logic [15:0]      lock_loss_cnt
`ifdef PRBS31_CHK_ERRMASK_EN
  ,
  output logic [31:0]      err_mask
`endif
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);
  localparam int SW = ((CNT_W > 6) ? CNT_W : 6) + 1;
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
  localparam logic [BW-1:0] BAD_LAST  = BW'(UNLOCK_CNT - 1);
  localparam logic [5:0]    BAD_BITS  = 6'(UNLOCK_BITS);
  localparam logic [SW-1:0] SAT       = SW'({CNT_W{1'b1}});

  state_t              state;
  logic [PRBS_W-1:0]   d1, prev, lfsr;
  logic                v1, prev_ok;
  logic [GW-1:0]       good_cnt;
  logic [BW-1:0]       bad_cnt;

  logic [PRBS_W-1:0]   expected, diff;
  logic [5:0]          pc;
  logic                word_err, word_bad, count_en, lock_drop;
  logic [SW-1:0]       bit_sum;
  logic [CNT_W-1:0]    bit_nxt;

  assign expected  = (state == LOCKED) ? lfsr : prbs31_nxt32(prev);
  assign diff      = expected ^ d1;
  assign word_err  = (pc != 6'd0);
  assign word_bad  = (pc >= BAD_BITS);
  assign count_en  = v1 && (state == LOCKED) && word_err;
  assign lock_drop = v1 && (state == LOCKED) && word_bad && (bad_cnt == BAD_LAST);
  assign locked    = (state == LOCKED);

  popcnt32 u_popcnt (
    .d   (diff),
    .cnt (pc)
  );

  // Wide enough that a full 32-bit error word cannot wrap a narrow counter.
  always_comb begin
    bit_sum = SW'(err_bit_cnt) + SW'(pc);
    bit_nxt = (bit_sum > SAT) ? '1 : bit_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SEARCH;
      d1       <= '0;
      v1       <= 1'b0;
      prev     <= '0;
      prev_ok  <= 1'b0;
      lfsr     <= '0;
      good_cnt <= '0;
      bad_cnt  <= '0;
      err_flag <= 1'b0;
      err_bits <= '0;
    end else begin
      v1       <= din_valid;
      err_flag <= 1'b0;
      if (din_valid) d1 <= din;
      if (v1) begin
        if (state == SEARCH) begin
          prev    <= d1;
          prev_ok <= 1'b1;
          if (prev_ok) begin
            err_bits <= pc;
            if (word_err) begin
              good_cnt <= '0;
            end else if (good_cnt == GOOD_LAST) begin
              state    <= LOCKED;
              lfsr     <= prbs31_nxt32(d1);
              good_cnt <= '0;
            end else begin
              good_cnt <= good_cnt + 1'b1;
            end
          end
        end else begin
          lfsr     <= prbs31_nxt32(lfsr);
          err_bits <= pc;
          err_flag <= word_err;
          if (!word_bad) begin
            bad_cnt <= '0;
          end else if (bad_cnt == BAD_LAST) begin
            state    <= SEARCH;
            bad_cnt  <= '0;
            good_cnt <= '0;
            prev_ok  <= 1'b0;
          end else begin
            bad_cnt <= bad_cnt + 1'b1;
          end
        end
      end
    end
  end

  // clr has priority over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_bit_cnt   <= '0;
      err_word_cnt  <= '0;
      lock_loss_cnt <= '0;
    end else if (clr) begin
      err_bit_cnt   <= '0;
      err_word_cnt  <= '0;
      lock_loss_cnt <= '0;
    end else begin
      if (count_en) begin
        err_bit_cnt <= bit_nxt;
        if (err_word_cnt != '1) err_word_cnt <= err_word_cnt + 1'b1;
      end
      if (lock_drop && (lock_loss_cnt != '1)) lock_loss_cnt <= lock_loss_cnt + 1'b1;
    end
  end

`ifdef PRBS31_CHK_ERRMASK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_mask <= '0;
    end else if (clr) begin
      err_mask <= '0;
    end else if (v1 && (state == LOCKED)) begin
      err_mask <= err_mask | diff;
    end
  end
`endif

endmodule

// File: tb/tb_prbs31_chk32b.sv
// Directed bench for prbs31_chk32b: lock, single errors, unlock/relock,
// clr priority, async reset, valid gaps and counter saturation (CNT_W=4).
module tb_prbs31_chk32b;
  import prbs31_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        din_valid;
  logic [31:0] din;
  logic        clr;

  logic        locked, err_flag, locked4, err_flag4;
  logic [5:0]  err_bits, err_bits4;
  logic [31:0] err_bit_cnt, err_word_cnt;
  logic [3:0]  err_bit_cnt4, err_word_cnt4;
  logic [15:0] lock_loss_cnt, lock_loss_cnt4;
`ifdef PRBS31_CHK_ERRMASK_EN
  logic [31:0] err_mask, err_mask4;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] g;
  int pcs[4];
  int pc_sum;
  logic allbad;

  always #5 clk = ~clk;

  prbs31_chk32b dut (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .clr(clr),
    .locked(locked), .err_flag(err_flag), .err_bits(err_bits),
    .err_bit_cnt(err_bit_cnt), .err_word_cnt(err_word_cnt),
    .lock_loss_cnt(lock_loss_cnt)
`ifdef PRBS31_CHK_ERRMASK_EN
    , .err_mask(err_mask)
`endif
  );

  prbs31_chk32b #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .clr(clr),
    .locked(locked4), .err_flag(err_flag4), .err_bits(err_bits4),
    .err_bit_cnt(err_bit_cnt4), .err_word_cnt(err_word_cnt4),
    .lock_loss_cnt(lock_loss_cnt4)
`ifdef PRBS31_CHK_ERRMASK_EN
    , .err_mask(err_mask4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    din       = w;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic send_clean();
    send(g);
    g = prbs31_nxt32(g);
  endtask

  task automatic idle();
    din_valid = 1'b0;
    din       = $urandom;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; din_valid = 1'b0; din = '0;

    // hand-derived next-word values
    chk("nxt_ffffffff", prbs31_nxt32(32'hFFFF_FFFF), 32'h0000_000E);
    chk("nxt_0000000e", prbs31_nxt32(32'h0000_000E), 32'h0000_00FC);
    chk("nxt_000000fc", prbs31_nxt32(32'h0000_00FC), 32'h0000_0E38);

    repeat (3) tick();
    chk("rst_locked",    32'(locked), 32'd0);
    chk("rst_err_flag",  32'(err_flag), 32'd0);
    chk("rst_err_bits",  32'(err_bits), 32'd0);
    chk("rst_bit_cnt",   err_bit_cnt, 32'd0);
    chk("rst_word_cnt",  err_word_cnt, 32'd0);
    chk("rst_lock_loss", 32'(lock_loss_cnt), 32'd0);
    rst_n = 1'b1;

    // initial lock: word 16 (0-based) completes the good run
    g = 32'hFFFF_FFFF;
    for (int i = 0; i <= 16; i++) send_clean();
    chk("lock_not_early", 32'(locked), 32'd0);
    send_clean();
    chk("lock_on_time", 32'(locked), 32'd1);
    repeat (10000) send_clean();
    chk("clean_locked",    32'(locked), 32'd1);
    chk("clean_bits",      32'(err_bits), 32'd0);
    chk("clean_bit_cnt",   err_bit_cnt, 32'd0);
    chk("clean_word_cnt",  err_word_cnt, 32'd0);
    chk("clean_lock_loss", 32'(lock_loss_cnt), 32'd0);

    // single flipped bit
    send(g ^ 32'h1); g = prbs31_nxt32(g);
    send_clean();
    chk("flip_flag",     32'(err_flag), 32'd1);
    chk("flip_bits",     32'(err_bits), 32'd1);
    chk("flip_bit_cnt",  err_bit_cnt, 32'd1);
    chk("flip_word_cnt", err_word_cnt, 32'd1);
    chk("flip_locked",   32'(locked), 32'd1);
    send_clean();
    chk("flip_flag_end", 32'(err_flag), 32'd0);
    chk("flip_word_hold", err_word_cnt, 32'd1);

    // four all-zero words drop lock
    allbad = 1'b1; pc_sum = 0;
    for (int k = 0; k < 4; k++) begin
      pcs[k] = $countones(g);
      pc_sum += pcs[k];
      allbad &= (pcs[k] >= 8);
      send(32'h0); g = prbs31_nxt32(g);
      if (k > 0) chk("zero_bits", 32'(err_bits), 32'(pcs[k-1]));
    end
    send_clean();  // resumed stream, loads prev in SEARCH
    chk("zero_bits_last", 32'(err_bits), 32'(pcs[3]));
    chk("zero_unlocked",  32'(locked), 32'(!allbad));
    chk("zero_lock_loss", 32'(lock_loss_cnt), 32'(allbad));
    chk("zero_word_cnt",  err_word_cnt, 32'd5);
    chk("zero_bit_cnt",   err_bit_cnt, 32'(1 + pc_sum));
    for (int i = 1; i <= 16; i++) send_clean();
    chk("relock_not_early", 32'(locked), 32'(!allbad));
    send_clean();
    chk("relock_on_time", 32'(locked), 32'd1);

    // clr coinciding with a 2-bit error word
    send(g ^ 32'h3); g = prbs31_nxt32(g);
    clr = 1'b1;
    send_clean();
    clr = 1'b0;
    chk("clr_word_cnt",  err_word_cnt, 32'd0);
    chk("clr_bit_cnt",   err_bit_cnt, 32'd0);
    chk("clr_lock_loss", 32'(lock_loss_cnt), 32'd0);
    chk("clr_word_cnt4", 32'(err_word_cnt4), 32'd0);
    chk("clr_locked",    32'(locked), 32'd1);
    send(g ^ 32'h1); g = prbs31_nxt32(g);
    send_clean();
    chk("post_clr_word", err_word_cnt, 32'd1);
    chk("post_clr_bit",  err_bit_cnt, 32'd1);

    // asynchronous reset between edges
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_locked",   32'(locked), 32'd0);
    chk("arst_word_cnt", err_word_cnt, 32'd0);
    chk("arst_bit_cnt",  err_bit_cnt, 32'd0);
    chk("arst_flag",     32'(err_flag), 32'd0);
    tick();
    rst_n = 1'b1;

    // clean stream with random valid gaps
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(1, 0) == 1) idle();
      send_clean();
    end
    repeat (5) idle();
    chk("gap_locked",    32'(locked), 32'd1);
    chk("gap_flag",      32'(err_flag), 32'd0);
    chk("gap_word_cnt",  err_word_cnt, 32'd0);
    chk("gap_bit_cnt",   err_bit_cnt, 32'd0);
    chk("gap_lock_loss", 32'(lock_loss_cnt), 32'd0);

    // 20 single-bit errors: CNT_W=4 instance saturates
    clr = 1'b1; idle(); clr = 1'b0;
    for (int k = 0; k < 20; k++) begin
      send(g ^ (32'h1 << (k % 32))); g = prbs31_nxt32(g);
    end
    send_clean();
    chk("sat_word_cnt4", 32'(err_word_cnt4), 32'hF);
    chk("sat_bit_cnt4",  32'(err_bit_cnt4), 32'hF);
    chk("sat_word_cnt",  err_word_cnt, 32'd20);
    chk("sat_bit_cnt",   err_bit_cnt, 32'd20);
    chk("sat_locked4",   32'(locked4), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
